// File: rtl/freq_control_pkg.sv
// Shared types and defaults for the frequency-counter sequencing master.
package freq_control_pkg;

   typedef enum logic [2:0] {
      IDLE,
      POLL,
      WAIT_GAP,
      RD_CNT,
      WR_TX,
      CLR
   } state_t;

   localparam logic [31:0] STATUS_ADDR_DEF = 32'h0000_0000;
   localparam logic [31:0] COUNT_ADDR_DEF  = 32'h0000_0004;
   localparam logic [31:0] TX_ADDR_DEF     = 32'h0000_0010;
   localparam int          DONE_BIT_DEF    = 5;
   localparam int          POLL_GAP_DEF    = 4;
   localparam int          TIMEOUT_DEF     = 16;

   // Every access is a full 32-bit word; the upper four selects are unused.
   localparam logic [7:0]  SEL_WORD        = 8'h0F;

   // Write-1-to-clear pattern that acknowledges only the done flag.
   function automatic logic [31:0] done_mask(input int bit_idx);
      return 32'h1 << bit_idx;
   endfunction

endpackage

// File: rtl/freq_control_unit_if.sv
// Wishbone B4 classic bus plus the tag hold/tag out pair seen by the sequencing master.
interface freq_control_unit_if;

   logic [31:0] addr_o;
   logic [31:0] dat_o;
   logic [31:0] dat_i;
   logic        we_o;
   logic [7:0]  sel_o;
   logic        cyc_o;
   logic        stb_o;
   logic        lock_o;
   logic        err_i;
   logic        rty_i;
   logic        ack_i;
   logic        tagn_i;
   logic        tagn_o;

   modport master (
      output addr_o, dat_o, we_o, sel_o, cyc_o, stb_o, lock_o, tagn_o,
      input  dat_i, err_i, rty_i, ack_i, tagn_i
   );

   modport slave (
      input  addr_o, dat_o, we_o, sel_o, cyc_o, stb_o, lock_o, tagn_o,
      output dat_i, err_i, rty_i, ack_i, tagn_i
   );

endinterface

// File: rtl/freq_control_unit_wb_single_access.sv
// Drives one Wishbone classic access at a time: registered bus outputs, rty
// reissue (by dropping the cycle while the request stays up) and, when
// CU_WATCHDOG_EN is defined, a watchdog that aborts unterminated cycles.
module wb_single_access
   import freq_control_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_dat,
   input  logic        req_we,
   input  logic        req_tx,
   input  logic [31:0] dat_i,
   input  logic        ack_i,
   input  logic        err_i,
   input  logic        rty_i,
   output logic [31:0] addr_o,
   output logic [31:0] dat_o,
   output logic        we_o,
   output logic [7:0]  sel_o,
   output logic        cyc_o,
   output logic        stb_o,
   output logic        tagn_o,
   output logic        done,
   output logic        fail,
   output logic [31:0] rd_data
);

`ifdef CU_WATCHDOG_EN
   localparam bit WD_EN = 1'b1;
`else
   localparam bit WD_EN = 1'b0;
`endif

   localparam int WDW = $clog2(TIMEOUT);

   logic [WDW-1:0] wd_cnt;
   logic           quiet;
   logic           err_hit;
   logic           rty_hit;
   logic           ack_hit;
   logic           wd_hit;

   // Termination decode with err > rty > ack priority.
   assign err_hit = cyc_o & err_i;
   assign rty_hit = cyc_o & ~err_i & rty_i;
   assign ack_hit = cyc_o & ~err_i & ~rty_i & ack_i;
   assign quiet   = cyc_o & ~err_i & ~rty_i & ~ack_i;
   assign wd_hit  = WD_EN & quiet & (wd_cnt == WDW'(TIMEOUT - 1));

   assign done    = ack_hit;
   assign fail    = err_hit | wd_hit;
   assign rd_data = dat_i;

   // Watchdog: counts unterminated cycles of the current strobe, cleared while idle.
   always_ff @(posedge clk_i) begin
      // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
      if (rst_i || !cyc_o) begin
         wd_cnt <= '0;
      end else begin
         wd_cnt <= wd_cnt + 1'b1;
      end
   end

   // Bus register: launch on request when idle, clear on any termination.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         addr_o <= '0;
         dat_o  <= '0;
         we_o   <= 1'b0;
         sel_o  <= '0;
         cyc_o  <= 1'b0;
         stb_o  <= 1'b0;
         tagn_o <= 1'b1;
      end else if (!cyc_o) begin
         if (req) begin
            addr_o <= req_addr;
            dat_o  <= req_we ? req_dat : '0;
            we_o   <= req_we;
            sel_o  <= SEL_WORD;
            cyc_o  <= 1'b1;
            stb_o  <= 1'b1;
            tagn_o <= ~req_tx;
         end
      end else if (err_hit || rty_hit || ack_hit || wd_hit) begin
         addr_o <= '0;
         dat_o  <= '0;
         we_o   <= 1'b0;
         sel_o  <= '0;
         cyc_o  <= 1'b0;
         stb_o  <= 1'b0;
         tagn_o <= 1'b1;
      end
   end

endmodule

// File: rtl/freq_control_unit.sv
// Sequencing master of the frequency counter: polls the status register, and on
// a finished measurement reads the count, forwards it to the UART transmit
// register and clears the done flag, holding the bus lock across that sequence.
// The optional access watchdog is enabled by defining CU_WATCHDOG_EN.
module freq_control_unit
   import freq_control_pkg::*;
#(
   parameter logic [31:0] STATUS_ADDR = STATUS_ADDR_DEF,
   parameter logic [31:0] COUNT_ADDR  = COUNT_ADDR_DEF,
   parameter logic [31:0] TX_ADDR     = TX_ADDR_DEF,
   parameter int          DONE_BIT    = DONE_BIT_DEF,
   parameter int          POLL_GAP    = POLL_GAP_DEF,
   parameter int          TIMEOUT     = TIMEOUT_DEF
) (
   input logic                 clk_i,
   input logic                 rst_i,
   freq_control_unit_if.master bus
);

   localparam int GW = $clog2(POLL_GAP + 1);

   state_t        state;
   state_t        state_nxt;
   logic [GW-1:0] gap_cnt;
   logic [31:0]   result;
   logic          acc_req;
   logic          acc_we;
   logic          acc_tx;
   logic [31:0]   acc_addr;
   logic [31:0]   acc_wdat;
   logic          acc_done;
   logic          acc_fail;
   logic [31:0]   acc_rdat;
   logic          tag_ok;
   logic          status_done;

   // An undriven or unknown hold input counts as "allowed"; unknown status bits count as 0.
   assign tag_ok      = (bus.tagn_i !== 1'b0);
   assign status_done = (acc_rdat[DONE_BIT] === 1'b1);

   wb_single_access #(
      .TIMEOUT (TIMEOUT)
   ) u_access (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .req      (acc_req),
      .req_addr (acc_addr),
      .req_dat  (acc_wdat),
      .req_we   (acc_we),
      .req_tx   (acc_tx),
      .dat_i    (bus.dat_i),
      .ack_i    (bus.ack_i),
      .err_i    (bus.err_i),
      .rty_i    (bus.rty_i),
      .addr_o   (bus.addr_o),
      .dat_o    (bus.dat_o),
      .we_o     (bus.we_o),
      .sel_o    (bus.sel_o),
      .cyc_o    (bus.cyc_o),
      .stb_o    (bus.stb_o),
      .tagn_o   (bus.tagn_o),
      .done     (acc_done),
      .fail     (acc_fail),
      .rd_data  (acc_rdat)
   );

   // State register.
   always_ff @(posedge clk_i) begin
      if (rst_i) state <= IDLE;
      else       state <= state_nxt;
   end

   // Next state and access request; the request stays up until the access ends.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path infers a latch.
      state_nxt = state;
      acc_req   = 1'b0;
      acc_we    = 1'b0;
      acc_tx    = 1'b0;
      acc_addr  = '0;
      acc_wdat  = '0;
      case (state)
         IDLE: begin
            if (tag_ok) state_nxt = POLL;
         end
         POLL: begin
            acc_req  = 1'b1;
            acc_addr = STATUS_ADDR;
            if (acc_fail)      state_nxt = WAIT_GAP;
            else if (acc_done) state_nxt = status_done ? RD_CNT : WAIT_GAP;
         end
         WAIT_GAP: begin
            if (gap_cnt == GW'(POLL_GAP - 1)) state_nxt = IDLE;
         end
         RD_CNT: begin
            acc_req  = 1'b1;
            acc_addr = COUNT_ADDR;
            if (acc_fail)      state_nxt = WAIT_GAP;
            else if (acc_done) state_nxt = WR_TX;
         end
         WR_TX: begin
            acc_req  = 1'b1;
            acc_we   = 1'b1;
            acc_tx   = 1'b1;
            acc_addr = TX_ADDR;
            acc_wdat = result;
            if (acc_fail)      state_nxt = WAIT_GAP;
            else if (acc_done) state_nxt = CLR;
         end
         CLR: begin
            acc_req  = 1'b1;
            acc_we   = 1'b1;
            acc_addr = STATUS_ADDR;
            acc_wdat = done_mask(DONE_BIT);
            if (acc_fail || acc_done) state_nxt = WAIT_GAP;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Idle-gap counter between polls.
   always_ff @(posedge clk_i) begin
      if (rst_i || state != WAIT_GAP) gap_cnt <= '0;
      else                            gap_cnt <= gap_cnt + 1'b1;
   end

   // Result register: the count captured when the count read is acknowledged.
   always_ff @(posedge clk_i) begin
      if (rst_i)                         result <= '0;
      else if (state == RD_CNT && acc_done) result <= acc_rdat;
   end

   // Bus lock: rises with the count read, held through rty gaps, dropped on abort or clear.
   always_ff @(posedge clk_i) begin
      if (rst_i)                          bus.lock_o <= 1'b0;
      else if (acc_fail)                  bus.lock_o <= 1'b0;
      else if (state == CLR && acc_done)  bus.lock_o <= 1'b0;
      else if (state == RD_CNT)           bus.lock_o <= 1'b1;
   end

endmodule

// File: tb/tb_freq_control_unit.sv
// Self-checking bench for freq_control_unit: a transaction-level model predicts
// the next expected bus access from the slave responses the bench itself gives.
module tb_freq_control_unit;

   localparam logic [31:0] STATUS_A = 32'h0000_0000;
   localparam logic [31:0] COUNT_A  = 32'h0000_0004;
   localparam logic [31:0] TX_A     = 32'h0000_0010;
   localparam logic [31:0] CLR_DAT  = 32'h0000_0020;
   localparam int          DONE_B   = 5;
   localparam int          GAP      = 4;
   localparam int          TMO      = 16;
`ifdef CU_WATCHDOG_EN
   localparam bit          WD       = 1'b1;
`else
   localparam bit          WD       = 1'b0;
`endif

   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [31:0] dat;
      logic        lock;
   } acc_t;

   typedef enum int {M_NONE, M_ACK, M_RAND} mode_t;

   logic clk = 1'b0;
   logic rst_i;

   freq_control_unit_if bus ();

   freq_control_unit dut (
      .clk_i (clk),
      .rst_i (rst_i),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int    n_cmp = 0;
   int    n_err = 0;
   acc_t  exp_acc;
   bit    hold_lock;
   int    busy_cycles;
   int    idle_cnt;
   int    last_end;       // 0 in-sequence, 1 retry, 2 into poll gap, 3 after reset
   bit    tag_blocked;
   mode_t mode;
   int    done_pct;
   bit    use_forced;
   logic [31:0] forced_count;
   bit    inject_rty_tx;
   bit    inject_err_rd;
   int    n_rty_tx = 0;
   int    n_err_rd = 0;
   int    n_starts = 0;
   int    n_rd_starts = 0;
   int    n_tx_starts = 0;
   int    n_clr = 0;
   int    n_tmo = 0;
   logic [31:0] seen_tx_dat;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic acc_t mk(input logic we, input logic [31:0] a, input logic [31:0] d, input logic l);
      acc_t r;
      r.we = we; r.addr = a; r.dat = d; r.lock = l;
      return r;
   endfunction

   task automatic model_reset();
      exp_acc     = mk(1'b0, STATUS_A, 32'h0, 1'b0);
      hold_lock   = 1'b0;
      busy_cycles = 0;
      idle_cnt    = 0;
      last_end    = 3;
      tag_blocked = 1'b0;
   endtask

   task automatic drive_quiet();
      bus.ack_i = 1'b0;
      bus.err_i = 1'b0;
      bus.rty_i = 1'b0;
      bus.dat_i = '0;
   endtask

   // Called at a negedge: one reset edge, then first poll strobe two edges after release.
   task automatic reset_and_check();
      rst_i = 1'b1;
      drive_quiet();
      @(negedge clk);
      check("rst_addr", bus.addr_o, 32'h0);
      check("rst_dat",  bus.dat_o, 32'h0);
      check("rst_we",   32'(bus.we_o), 32'h0);
      check("rst_sel",  32'(bus.sel_o), 32'h0);
      check("rst_cyc",  32'(bus.cyc_o), 32'h0);
      check("rst_stb",  32'(bus.stb_o), 32'h0);
      check("rst_lock", 32'(bus.lock_o), 32'h0);
      check("rst_tagn", 32'(bus.tagn_o), 32'h1);
      rst_i = 1'b0;
      @(negedge clk);
      check("cyc_edge1", 32'(bus.cyc_o), 32'h0);
      @(negedge clk);
      check("cyc_edge2", 32'(bus.cyc_o), 32'h1);
      model_reset();
   endtask

   // One bus cycle, entered and left at a negedge.
   task automatic step();
      logic [31:0] rd_val;
      bit is_poll, is_rd, is_tx;
      logic a, e, y;
      is_poll = !exp_acc.we && exp_acc.addr == STATUS_A;
      is_rd   = !exp_acc.we && exp_acc.addr == COUNT_A;
      is_tx   =  exp_acc.we && exp_acc.addr == TX_A;
      a = 1'b0; e = 1'b0; y = 1'b0;
      rd_val = $urandom;
      if (bus.cyc_o === 1'b1) begin
         if (busy_cycles == 0) begin
            if (last_end == 1) check("rty_gap", 32'(idle_cnt), 32'h1);
            else if (last_end == 2 && !tag_blocked)
               check("poll_gap", 32'(idle_cnt >= GAP && idle_cnt <= GAP + 2), 32'h1);
            tag_blocked = 1'b0;
            n_starts++;
            if (is_rd) n_rd_starts++;
            if (is_tx) n_tx_starts++;
         end
         check("stb",  32'(bus.stb_o), 32'h1);
         check("addr", bus.addr_o, exp_acc.addr);
         check("we",   32'(bus.we_o), 32'(exp_acc.we));
         check("sel",  32'(bus.sel_o), 32'h0F);
         check("wdat", bus.dat_o, exp_acc.we ? exp_acc.dat : 32'h0);
         check("lock", 32'(bus.lock_o), 32'(exp_acc.lock));
         check("tagn", 32'(bus.tagn_o), is_tx ? 32'h0 : 32'h1);
         if (is_tx) seen_tx_dat = bus.dat_o;
         case (mode)
            M_NONE: ;
            M_ACK: begin
               a = 1'b1;
               if (inject_rty_tx && is_tx) begin y = 1'b1; inject_rty_tx = 1'b0; n_rty_tx++; end
               if (inject_err_rd && is_rd) begin e = 1'b1; inject_err_rd = 1'b0; n_err_rd++; end
            end
            default: begin
               a = ($urandom_range(0, 99) < 60);
               y = ($urandom_range(0, 99) < 15);
               e = ($urandom_range(0, 99) < 8);
            end
         endcase
         if (is_poll) rd_val[DONE_B] = ($urandom_range(0, 99) < done_pct);
         if (is_rd && use_forced) rd_val = forced_count;
         bus.ack_i = a;
         bus.err_i = e;
         bus.rty_i = y;
         bus.dat_i = rd_val;
         busy_cycles++;
         idle_cnt = 0;
         if (e) begin
            exp_acc = mk(1'b0, STATUS_A, 32'h0, 1'b0); hold_lock = 1'b0; last_end = 2; busy_cycles = 0;
         end else if (y) begin
            hold_lock = exp_acc.lock; last_end = 1; busy_cycles = 0;
         end else if (a) begin
            busy_cycles = 0;
            if (is_poll) begin
               hold_lock = 1'b0;
               if (rd_val[DONE_B]) begin exp_acc = mk(1'b0, COUNT_A, 32'h0, 1'b1); last_end = 0; end
               else last_end = 2;
            end else if (is_rd) begin
               exp_acc = mk(1'b1, TX_A, rd_val, 1'b1); hold_lock = 1'b1; last_end = 0;
            end else if (is_tx) begin
               exp_acc = mk(1'b1, STATUS_A, CLR_DAT, 1'b1); hold_lock = 1'b1; last_end = 0;
            end else begin
               exp_acc = mk(1'b0, STATUS_A, 32'h0, 1'b0); hold_lock = 1'b0; last_end = 2; n_clr++;
            end
         end else if (WD && busy_cycles == TMO) begin
            exp_acc = mk(1'b0, STATUS_A, 32'h0, 1'b0); hold_lock = 1'b0; last_end = 2;
            busy_cycles = 0; n_tmo++;
         end
      end else begin
         check("idle_stb",  32'(bus.stb_o), 32'h0);
         check("idle_addr", bus.addr_o, 32'h0);
         check("idle_dat",  bus.dat_o, 32'h0);
         check("idle_we",   32'(bus.we_o), 32'h0);
         check("idle_sel",  32'(bus.sel_o), 32'h0);
         check("idle_tagn", 32'(bus.tagn_o), 32'h1);
         check("idle_lock", 32'(bus.lock_o), 32'(hold_lock));
         drive_quiet();
         bus.dat_i = rd_val;
         idle_cnt++;
         if (bus.tagn_i === 1'b0) tag_blocked = 1'b1;
      end
      @(negedge clk);
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic run_until_clr(input int target, input int limit);
      for (int i = 0; i < limit && n_clr < target; i++) step();
      check("clr_reached", 32'(n_clr), 32'(target));
   endtask

   initial begin
      int base;
      int base_tx;
      mode          = M_NONE;
      done_pct      = 0;
      use_forced    = 1'b0;
      forced_count  = '0;
      inject_rty_tx = 1'b0;
      inject_err_rd = 1'b0;
      seen_tx_dat   = '0;
      bus.tagn_i    = 1'b1;
      model_reset();

      // Reset values and first poll timing, then ack tied low.
      reset_and_check();
      run(3 * TMO + 4);
`ifdef CU_WATCHDOG_EN
      check("watchdog_aborts", 32'(n_tmo >= 2), 32'h1);
`else
      check("no_watchdog_hold", 32'(busy_cycles > TMO), 32'h1);
`endif

      // Plain polling: status never done, the count register is never read.
      mode = M_ACK;
      base = n_rd_starts;
      run(40);
      check("no_count_read", 32'(n_rd_starts), 32'(base));

      // Full measurement sequence with a known count.
      done_pct     = 100;
      use_forced   = 1'b1;
      forced_count = 32'h0001_2345;
      run_until_clr(n_clr + 1, 60);
      done_pct = 0;
      check("tx_data", seen_tx_dat, 32'h0001_2345);

      // Retry on the transmit write: the same write is reissued once.
      done_pct      = 100;
      forced_count  = 32'hA5C3_0F96;
      base_tx       = n_tx_starts;
      inject_rty_tx = 1'b1;
      run_until_clr(n_clr + 1, 60);
      done_pct = 0;
      check("rty_seen", 32'(n_rty_tx), 32'h1);
      check("tx_reissued", 32'(n_tx_starts - base_tx), 32'h2);
      check("tx_data_rty", seen_tx_dat, 32'hA5C3_0F96);

      // Error on the count read: sequence abandoned, polling resumes.
      done_pct      = 100;
      inject_err_rd = 1'b1;
      for (int i = 0; i < 40 && n_err_rd == 0; i++) step();
      done_pct = 0;
      check("err_seen", 32'(n_err_rd), 32'h1);
      base_tx = n_tx_starts;
      base    = n_starts;
      run(20);
      check("no_tx_after_err", 32'(n_tx_starts), 32'(base_tx));
      check("poll_resumed", 32'(n_starts > base), 32'h1);

      // Hold input low: bus goes quiet, restarts once released.
      bus.tagn_i = 1'b0;
      run(10);
      base = n_starts;
      run(25);
      check("tag_hold_quiet", 32'(n_starts), 32'(base));
      bus.tagn_i = 1'b1;
      for (int i = 0; i < 4 && n_starts == base; i++) step();
      check("tag_release_poll", 32'(n_starts > base), 32'h1);

      // Randomised responses, including simultaneous terminations.
      mode       = M_RAND;
      done_pct   = 40;
      use_forced = 1'b0;
      run(600);

      // Reset in the middle of a locked sequence.
      mode     = M_ACK;
      done_pct = 100;
      for (int i = 0; i < 60 && !(bus.cyc_o === 1'b1 && bus.lock_o === 1'b1); i++) step();
      check("locked_seq_found", 32'(bus.cyc_o === 1'b1 && bus.lock_o === 1'b1), 32'h1);
      reset_and_check();
      done_pct = 0;
      run(30);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/freq_control_unit.md
# freq_control_unit

Sequencing master of the frequency counter: a Wishbone B4 classic single-access master that polls the counter's status register and, when a measurement is done, reads the count and forwards it to the UART transmit register. It then acknowledges the measurement by clearing the done flag. It sits between the counter core and the UART interface on the shared Wishbone bus and is the only bus master.

## Interface
- STATUS_ADDR, 32'h0000_0000, counter status register address
- COUNT_ADDR, 32'h0000_0004, counter result register address
- TX_ADDR, 32'h0000_0010, UART transmit data register address
- DONE_BIT, 5, bit index of "measurement done" in the status word
- POLL_GAP, 4, idle cycles between consecutive status polls (≥1)
- TIMEOUT, 16, cycles without ack/err/rty before a cycle is aborted (≥2)
- clk_i  in  1  single clock, all logic on rising edge
- rst_i  in  1  reset, synchronous, active-high
- addr_o  out  32  bus address
- dat_o  out  32  write data
- dat_i  in  32  read data
- we_o  out  1  1 = write cycle
- sel_o  out  8  byte selects; [3:0] = lanes of the 32-bit word, [7:4] always 0
- cyc_o, stb_o  out  1  Wishbone cycle / strobe
- lock_o  out  1  bus lock across the read-count/write-tx/clear sequence
- err_i, rty_i, ack_i  in  1  slave termination signals
- tagn_i  in  1  active-low hold: 0 prevents starting a new poll
- tagn_o  out  1  active-low tag, 0 while the result write to TX_ADDR is on the bus

## Operation
- States: IDLE, POLL, WAIT_GAP, RD_CNT, WR_TX, CLR, each bus state holds cyc_o=stb_o=1 until terminated.
- IDLE: if tagn_i != 0 (1 or unknown treated as 1) → POLL next cycle.
- POLL: read STATUS_ADDR, sel_o=8'h0F, we_o=0. On ack: dat_i[DONE_BIT]=1 → RD_CNT, else → WAIT_GAP.
- WAIT_GAP: bus idle for POLL_GAP cycles → IDLE.
- RD_CNT: read COUNT_ADDR, lock_o=1; on ack capture dat_i into result register → WR_TX.
- WR_TX: write result to TX_ADDR, we_o=1, sel_o=8'h0F, lock_o=1, tagn_o=0 → CLR on ack.
- CLR: write STATUS_ADDR with only bit DONE_BIT set (write-1-to-clear), lock_o=1 → WAIT_GAP on ack.
- Termination priority when several assert together: err_i > rty_i > ack_i.
- rty_i: drop cyc/stb for one cycle, reissue the same access (lock_o kept).
- err_i, or watchdog timeout: drop cyc/stb/lock, discard sequence → WAIT_GAP.
- Inputs other than the terminating ones with X/Z are treated as 0.

## Timing
- Reset values: addr_o=0, dat_o=0, we_o=0, sel_o=0, cyc_o=0, stb_o=0, lock_o=0, tagn_o=1; state IDLE, result register 0.
- All outputs registered; first POLL cycle begins 1 cycle after IDLE with tagn_i=1 (cyc_o rises at 2nd edge after rst_i falls).
- Termination sampled on the rising edge; cyc_o/stb_o deassert the next cycle (one access per cycle, no pipelining).
- addr_o/dat_o/we_o/sel_o stable throughout each cycle; zeroed when bus idle.
- Reset mid-cycle: all outputs return to reset values on the next edge, no completion.
- Timeout counter restarts at each new stb_o assertion; abort on the TIMEOUT-th unterminated cycle.

## Configuration
- CU_WATCHDOG_EN defined: TIMEOUT watchdog active as above.
- Undefined: no watchdog; a cycle waits indefinitely for ack_i/err_i/rty_i; TIMEOUT parameter ignored.

## Structure
- Package freq_control_pkg: state enum, default register addresses, DONE_BIT default, sel constant 8'h0F.
- One sub-module wb_single_access: drives one Wishbone access, handles rty reissue and watchdog, reports done/err/data to the sequencing FSM.

## Test plan
- Reset held 1 cycle, ack_i tied 0 → all outputs at reset values; poll cycles on STATUS_ADDR abort every TIMEOUT cycles with watchdog enabled.
- Ack every cycle, dat_i=0 → repeated reads of 0x0, POLL_GAP idle cycles between them, no access to 0x4.
- Ack every cycle, dat_i[5]=1 and count 0x0001_2345 → read 0x0, read 0x4, write 0x0001_2345 to 0x10 with tagn_o=0, write 0x20 to 0x0; lock_o high across last three.
- rty_i on the WR_TX cycle → one idle cycle, identical write reissued, lock_o stays 1.
- err_i on RD_CNT → cyc/lock drop, no TX write, polling resumes after POLL_GAP.
- tagn_i=0 in IDLE → no bus activity until tagn_i returns 1.
